// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC and FSM state encodings.
package if_stage_pkg;

    localparam int unsigned IF_ISIZE = 32;
    localparam logic [IF_ISIZE-1:0] IF_RESET_PC = '0;

    // RUN: fetching normally; HOLD: skid buffer full, waiting on decode;
    // KILL: draining a request that a branch made stale.
    typedef enum logic [1:0] {
        IF_RUN  = 2'd0,
        IF_HOLD = 2'd1,
        IF_KILL = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage with integrated IF/ID register and one-entry skid buffer.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned      ISIZE    = IF_ISIZE,
    parameter logic [ISIZE-1:0] RESET_PC = ISIZE'(IF_RESET_PC),
    parameter logic [ISIZE-1:0] PC_STEP  = ISIZE'(1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [ISIZE-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [ISIZE-1:0] imem_rdata,
    input  logic             stall_in,
    input  logic             branch_taken_in,
    input  logic [ISIZE-1:0] branch_target_in,
    output logic [ISIZE-1:0] instr_out,
    output logic [ISIZE-1:0] nPC_out,
    output logic             valid_out
);

    if_state_e        state_q, state_d;
    logic [ISIZE-1:0] pc_q, pc_d;
    logic [ISIZE-1:0] kill_addr_q, kill_addr_d;
    logic [ISIZE-1:0] buf_instr_q, buf_instr_d;
    logic [ISIZE-1:0] buf_npc_q, buf_npc_d;
    logic [ISIZE-1:0] instr_d;
    logic [ISIZE-1:0] npc_d;
    logic             valid_d;
    logic [ISIZE-1:0] pc_inc;

    // Sequential PC arithmetic wraps silently at 2^ISIZE.
    assign pc_inc = pc_q + PC_STEP;

    // Next-state, memory request and IF/ID register next values.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        buf_instr_d = buf_instr_q;
        buf_npc_d   = buf_npc_q;
        instr_d     = instr_out;
        npc_d       = nPC_out;
        valid_d     = valid_out;
        imem_req    = 1'b0;
        imem_addr   = pc_q;

        case (state_q)
            IF_RUN: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (branch_taken_in) begin
                        // Fetched word is on the wrong path: drop it.
                        pc_d    = branch_target_in;
                        valid_d = 1'b0;
                    end else if (stall_in && valid_out) begin
                        // Decode is full; park the word and stop fetching.
                        buf_instr_d = imem_rdata;
                        buf_npc_d   = pc_inc;
                        pc_d        = pc_inc;
                        state_d     = IF_HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        npc_d   = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end else if (branch_taken_in) begin
                    // The pending request cannot be withdrawn; remember where it went.
                    kill_addr_d = pc_q;
                    pc_d        = branch_target_in;
                    valid_d     = 1'b0;
                    state_d     = IF_KILL;
                end else if (!stall_in) begin
                    valid_d = 1'b0;
                end
            end

            IF_HOLD: begin
                if (branch_taken_in) begin
                    pc_d    = branch_target_in;
                    valid_d = 1'b0;
                    state_d = IF_RUN;
                end else if (!stall_in) begin
                    instr_d = buf_instr_q;
                    npc_d   = buf_npc_q;
                    valid_d = 1'b1;
                    state_d = IF_RUN;
                end
            end

            IF_KILL: begin
                imem_req  = 1'b1;
                imem_addr = kill_addr_q;
                valid_d   = 1'b0;
                if (branch_taken_in) begin
                    pc_d = branch_target_in;
                end
                if (imem_ack) begin
                    state_d = IF_RUN;
                end
            end

            default: begin
                state_d = IF_RUN;
                valid_d = 1'b0;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // State, PC, skid buffer and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IF_RUN;
            pc_q        <= RESET_PC;
            kill_addr_q <= '0;
            buf_instr_q <= '0;
            buf_npc_q   <= '0;
            instr_out   <= '0;
            nPC_out     <= '0;
            valid_out   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_npc_q   <= buf_npc_d;
            instr_out   <= instr_d;
            nPC_out     <= npc_d;
            valid_out   <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: transaction-level model plus pinned literals.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic [31:0] instr_out;
    logic [31:0] nPC_out;
    logic        valid_out;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model of what decode should see and what fetch should request.
    logic [31:0] m_pc        = 32'd0;  // next address to fetch on the live path
    bit          m_draining  = 1'b0;   // a stale request is still outstanding
    logic [31:0] m_stale     = 32'd0;  // address of that stale request
    bit          m_parked    = 1'b0;   // one fetched word waits for decode
    logic [31:0] m_park_ins  = 32'd0;
    logic [31:0] m_park_npc  = 32'd0;
    logic [31:0] m_ins       = 32'd0;
    logic [31:0] m_npc       = 32'd0;
    bit          m_valid     = 1'b0;

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .instr_out        (instr_out),
        .nPC_out          (nPC_out),
        .valid_out        (valid_out)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Instruction memory: content is a fixed function of address.
    assign imem_rdata = word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step();
        if (rst) begin
            m_pc = 32'd0; m_draining = 1'b0; m_parked = 1'b0;
            m_ins = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
        end else if (m_parked) begin
            if (branch_taken_in) begin
                m_parked = 1'b0; m_pc = branch_target_in; m_valid = 1'b0;
            end else if (!stall_in) begin
                m_ins = m_park_ins; m_npc = m_park_npc; m_valid = 1'b1;
                m_parked = 1'b0;
            end
        end else if (m_draining) begin
            m_valid = 1'b0;
            if (branch_taken_in) m_pc = branch_target_in;
            if (imem_ack) m_draining = 1'b0;
        end else if (imem_ack) begin
            if (branch_taken_in) begin
                m_pc = branch_target_in; m_valid = 1'b0;
            end else if (stall_in && m_valid) begin
                m_parked = 1'b1; m_park_ins = word(m_pc); m_park_npc = m_pc + 32'd1;
                m_pc = m_pc + 32'd1;
            end else begin
                m_ins = word(m_pc); m_npc = m_pc + 32'd1; m_valid = 1'b1;
                m_pc = m_pc + 32'd1;
            end
        end else if (branch_taken_in) begin
            m_draining = 1'b1; m_stale = m_pc; m_pc = branch_target_in; m_valid = 1'b0;
        end else if (!stall_in) begin
            m_valid = 1'b0;
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("imem_req", 32'(imem_req), 32'(!rst && !m_parked));
                if (!rst && !m_parked)
                    chk("imem_addr", imem_addr, m_draining ? m_stale : m_pc);
                chk("valid_out", 32'(valid_out), 32'(m_valid));
                if (m_valid) begin
                    chk("instr_out", instr_out, m_ins);
                    chk("nPC_out", nPC_out, m_npc);
                end
            end
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the clock edge.
    task automatic cyc(input bit r, input bit ack, input bit st, input bit br, input logic [31:0] tgt);
        rst              = r;
        imem_ack         = ack;
        stall_in         = st;
        branch_taken_in  = br;
        branch_target_in = tgt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall_in = 1'b0;
        branch_taken_in = 1'b0; branch_target_in = 32'd0;

        // Reset.
        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0, 0);
        chk("rst valid", 32'(valid_out), 32'd0);
        chk("rst instr", instr_out, 32'd0);
        chk("rst npc", nPC_out, 32'd0);
        chk("rst req", 32'(imem_req), 32'd0);

        // Zero-wait streaming from address 0.
        cyc(0, 1, 0, 0, 0);
        chk("stream addr1", imem_addr, 32'd1);
        chk("stream ins0", instr_out, 32'hC0DE_0000);
        chk("stream npc1", nPC_out, 32'd1);
        chk("stream valid", 32'(valid_out), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        chk("stream addr4", imem_addr, 32'd4);
        chk("stream ins3", instr_out, 32'hC0DE_0003);
        chk("stream npc4", nPC_out, 32'd4);

        // Two wait states per fetch.
        for (int r = 0; r < 3; r++) begin
            cyc(0, 0, 0, 0, 0);
            if (r == 0) begin
                chk("wait bubble", 32'(valid_out), 32'd0);
                chk("wait addr", imem_addr, 32'd4);
            end
            cyc(0, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0);
            if (r == 0) begin
                chk("wait ins4", instr_out, 32'hC0DE_0004);
                chk("wait npc5", nPC_out, 32'd5);
            end
        end

        // Stall for three cycles while valid; one word parks in the skid buffer.
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        chk("stall ins7", instr_out, 32'hC0DE_0007);
        chk("stall npc8", nPC_out, 32'd8);
        chk("stall req", 32'(imem_req), 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("unstall ins8", instr_out, 32'hC0DE_0008);
        chk("unstall npc9", nPC_out, 32'd9);
        cyc(0, 1, 0, 0, 0);

        // Branch while the request to 0x05 is unacked.
        cyc(0, 1, 0, 1, 32'h5);
        cyc(0, 0, 0, 1, 32'h40);
        chk("kill addr", imem_addr, 32'h5);
        chk("kill req", 32'(imem_req), 32'd1);
        chk("kill valid", 32'(valid_out), 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("kill done addr", imem_addr, 32'h40);
        chk("kill done valid", 32'(valid_out), 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("target ins", instr_out, 32'hC0DE_0040);
        chk("target npc", nPC_out, 32'h41);

        // Branch while parked in the skid buffer under stall.
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 32'h80);
        chk("hold br valid", 32'(valid_out), 32'd0);
        chk("hold br addr", imem_addr, 32'h80);
        chk("hold br req", 32'(imem_req), 32'd1);
        cyc(0, 1, 0, 0, 0);

        // Reset arriving mid-drain together with the ack.
        cyc(0, 0, 0, 1, 32'h20);
        cyc(1, 1, 0, 0, 0);
        chk("rst kill req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("rst kill addr", imem_addr, 32'd0);
        chk("rst kill valid", 32'(valid_out), 32'd0);

        // PC wrap from all-ones to zero.
        cyc(0, 1, 0, 1, 32'hFFFF_FFFF);
        cyc(0, 1, 0, 0, 0);
        chk("wrap ins", instr_out, 32'h3F21_FFFF);
        chk("wrap npc", nPC_out, 32'd0);
        chk("wrap addr", imem_addr, 32'd0);

        // Mixed traffic, checked by the per-cycle model comparison.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                32'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
